// File: rtl/dm_pkg.sv
// dm_pkg: size codes, FSM and response types, byte-enable and load-extend helpers
package dm_pkg;
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;
  typedef enum logic {CLEAR, RUN} state_t;
  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        e;
  } rsp_t;
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
    return size == SIZE_B ? 4'b0001 << a : size == SIZE_H ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    return size == SIZE_B ? {{24{~uns & s[7]}}, s[7:0]} :
           size == SIZE_H ? {{16{~uns & s[15]}}, s[15:0]} : w;
  endfunction
endpackage

// File: rtl/dm_lane_ext.sv
// dm_lane_ext: picks the addressed byte/half lane of a word and sign- or zero-extends it
module dm_lane_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);
  assign result = load_ext(word, addr_lo, size, uns);
endmodule

// File: rtl/dm_banked_lsu.sv
// dm_banked_lsu: byte-addressable data memory with clear engine, range/alignment checks and fixed-latency responses
module dm_banked_lsu
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          READ_LAT  = 1,
  parameter bit          TRACE     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic        busy
);
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  state_t        state;
  logic [IW-1:0] clear_idx;
  logic [31:0]   mem [DEPTH];
  rsp_t          pipe [READ_LAT];
  logic [32:0]   diff;
  logic [31:0]   off, rd_word, ext, wrep, bmask, merged;
  logic [3:0]    be;
  logic [IW-1:0] widx;
  logic          acc, exc;
  assign busy      = state == CLEAR;
  assign req_ready = state == RUN;
  assign acc       = req_valid && req_ready && !reset;
  assign diff      = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign off       = diff[31:0];
  assign widx      = off[IW+1:2];
  assign exc       = diff[32] || off >= LIMIT || req_size == SIZE_RSV ||
                     (req_size == SIZE_H && req_addr[0]) ||
                     (req_size == SIZE_W && req_addr[1:0] != 2'b00);
  assign rd_word   = mem[widx];
  assign be        = be_gen(req_size, req_addr[1:0]);
  assign bmask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wrep      = req_size == SIZE_B ? {4{req_wdata[7:0]}} :
                     req_size == SIZE_H ? {2{req_wdata[15:0]}} : req_wdata;
  assign merged    = (wrep & bmask) | (rd_word & ~bmask);
  dm_lane_ext u_ext (
    .word    (rd_word),
    .addr_lo (req_addr[1:0]),
    .size    (req_size),
    .uns     (req_unsigned),
    .result  (ext)
  );
  // CLEAR walks every word index once after reset, then hands over to RUN
  always_ff @(posedge clk)
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else if (state == CLEAR) begin
      clear_idx <= clear_idx + 1'b1;
      if (clear_idx == IW'(DEPTH - 1)) state <= RUN;
    end
  // single write port: zeroing during CLEAR, otherwise a checked store's merged word
  always_ff @(posedge clk)
    if (!reset && state == CLEAR) mem[clear_idx] <= '0;
    else if (acc && req_we && !exc) mem[widx] <= merged;
  // store trace for simulation logs, emitted only for committed writes
  always_ff @(posedge clk)
    if (TRACE && acc && req_we && !exc) $write("@%h: *%h <= %h\n", req_pc, {req_addr[31:2], 2'b00}, merged);
  // response delay line; load data is captured at accept so later stores cannot leak in
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: acc, d: (acc && !req_we && !exc) ? ext : '0, e: acc && exc};
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign rsp_valid = pipe[READ_LAT-1].v;
  assign rsp_rdata = pipe[READ_LAT-1].d;
  assign rsp_exc   = pipe[READ_LAT-1].e;
endmodule
